turn_scheduler: RTL

Controller that sequences the two HC-SR04 sensor interfaces of the Snake Game Arcade datapath and converts their proximity result into the 2-bit `direction` bus that feeds the head-position mux and wall detector. It issues periodic shared `medir` pulses, collects both `pronto` flags with a timeout and recovery reset, and debounces the `esq`/`dir` verdict over consecutive samples. It commits at most one relative turn per snake move, aligned to the move tick from the main control FSM.

---
 rtl/sga_pkg.sv | 23 ++
 rtl/contador_m.sv | 15 +
 rtl/turn_filter.sv | 50 +++++
 rtl/turn_scheduler.sv | 79 +++++++
 4 files changed

// File: rtl/sga_pkg.sv
// sga_pkg: shared state, direction and sample codes for the turn scheduler
package sga_pkg;
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ESPERA   = 4'd1,
    MEDE     = 4'd2,
    AGUARDA  = 4'd3,
    AVALIA   = 4'd4,
    RECUPERA = 4'd5
  } state_t;
  typedef enum logic [1:0] {
    S_NULL = 2'd0,
    S_L    = 2'd1,
    S_R    = 2'd2
  } sample_t;
  localparam logic [1:0] DIR_XP = 2'b00;
  localparam logic [1:0] DIR_YP = 2'b01;
  localparam logic [1:0] DIR_XN = 2'b10;
  localparam logic [1:0] DIR_YN = 2'b11;
  function automatic sample_t classify(input logic esq, input logic dir);
    return (esq && !dir) ? S_L : (dir && !esq) ? S_R : S_NULL;
  endfunction
endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M up counter with synchronous clear and terminal flag
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic clock,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);
  logic [N-1:0] q;
  always_ff @(posedge clock)
    q <= zera_s ? '0 : !conta ? q : fim ? '0 : q + 1'b1;
  assign fim = q == N'(M - 1);
endmodule

// File: rtl/turn_filter.sv
// turn_filter: debounces L/R samples and applies one confirmed turn per move tick
module turn_filter
  import sga_pkg::*;
#(
  parameter int CONFIRM = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       clear_count,
  input  logic       sample_valid,
  input  logic       esq,
  input  logic       dir,
  input  logic       move_tick,
  output logic [1:0] direction,
  output logic       turn_pending
);
  sample_t    last, pend, smp;
  logic [3:0] cnt, cnt_inc;
  logic       confirm;
  always_comb begin
    smp     = classify(esq, dir);
    cnt_inc = smp == S_NULL ? 4'd0 : smp != last ? 4'd1 :
              cnt >= 4'(CONFIRM) ? 4'(CONFIRM) : cnt + 4'd1;
    confirm = smp != S_NULL && cnt_inc == 4'(CONFIRM);
  end
  // tick acts on the registered pending, so a confirm in the same cycle waits for the next tick
  always_ff @(posedge clock)
    if (reset) begin
      direction <= DIR_XP;
      pend      <= S_NULL;
      last      <= S_NULL;
      cnt       <= '0;
    end else if (clear) begin
      pend <= S_NULL;
      cnt  <= '0;
    end else begin
      if (move_tick && pend != S_NULL) begin
        direction <= pend == S_R ? direction + 2'd1 : direction - 2'd1;
        pend      <= S_NULL;
      end
      if (clear_count) cnt <= '0;
      if (sample_valid) begin
        last <= smp;
        cnt  <= confirm ? 4'd0 : cnt_inc;
        if (confirm && pend == S_NULL) pend <= smp;
      end
    end
  assign turn_pending = pend != S_NULL;
endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: sequences both ultrasonic sensors and turns the debounced verdict into a direction
module turn_scheduler
  import sga_pkg::*;
#(
  parameter int PERIOD  = 400000,
  parameter int TIMEOUT = 2000000,
  parameter int CONFIRM = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       move_tick,
  input  logic       pronto_esq,
  input  logic       pronto_dir,
  input  logic       esq,
  input  logic       dir,
  output logic       medir,
  output logic       reset_interface,
  output logic [1:0] direction,
  output logic       turn_pending,
  output logic       timeout_err,
  output logic [3:0] db_estado
);
  localparam int PW = $clog2(PERIOD + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic   p_fim, t_fim, lat_esq, lat_dir, done;
  // ESPERA spans PERIOD+1 cycles so the first medir lands PERIOD+2 cycles after enable
  contador_m #(.M(PERIOD + 1), .N(PW)) u_periodo (
    .clock (clock),
    .zera_s(reset || state != ESPERA),
    .conta (state == ESPERA),
    .fim   (p_fim)
  );
  contador_m #(.M(TIMEOUT), .N(TW)) u_timeout (
    .clock (clock),
    .zera_s(reset || state != AGUARDA),
    .conta (state == AGUARDA),
    .fim   (t_fim)
  );
  assign done = (lat_esq | pronto_esq) & (lat_dir | pronto_dir);
  always_ff @(posedge clock) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ESPERA;
      ESPERA:  nxt = p_fim ? MEDE : ESPERA;
      MEDE:    nxt = AGUARDA;
      AGUARDA: nxt = done ? AVALIA : t_fim ? RECUPERA : AGUARDA;
      default: nxt = ESPERA;
    endcase
    if (!enable) nxt = IDLE;
  end
  always_ff @(posedge clock)
    if (reset || !enable || state == MEDE) begin
      lat_esq <= 1'b0;
      lat_dir <= 1'b0;
    end else if (state == AGUARDA) begin
      lat_esq <= lat_esq | pronto_esq;
      lat_dir <= lat_dir | pronto_dir;
    end
  always_ff @(posedge clock)
    timeout_err <= reset ? 1'b0 : timeout_err | (state == RECUPERA);
  assign medir           = state == MEDE && !reset;
  assign reset_interface = state == RECUPERA && !reset;
  assign db_estado       = state;
  turn_filter #(.CONFIRM(CONFIRM)) u_filter (
    .clock       (clock),
    .reset       (reset),
    .clear       (!enable),
    .clear_count (state == RECUPERA),
    .sample_valid(state == AVALIA),
    .esq         (esq),
    .dir         (dir),
    .move_tick   (move_tick),
    .direction   (direction),
    .turn_pending(turn_pending)
  );
endmodule
